// File: rtl/edge_pkg.sv
// +---------------------------------------------------------------------------+
// | edge_pkg : shared widths, types and helpers for the edge event reader.     |
// | Revision : 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package edge_pkg;

  localparam int EDGE_WIDTH = 32;

  typedef logic [EDGE_WIDTH-1:0]         edge_vec_t;
  typedef logic [$clog2(EDGE_WIDTH)-1:0] edge_idx_t;

  // Next index after i in a ring of w entries.
  function automatic int wrap_inc(input int i, input int w);
    return (i + 1 >= w) ? 0 : i + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_find_first.sv
// +---------------------------------------------------------------------------+
// | edge_find_first : first set bit of vec_i, searching upward from start_i    |
// |                   and wrapping past WIDTH-1 to 0.                          |
// | Revision        : 1.0                                                      |
// +---------------------------------------------------------------------------+
`default_nettype none

module edge_find_first
  import edge_pkg::*;
#(
  parameter int WIDTH = EDGE_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  int pos;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int k = 0; k < WIDTH; k++) begin
      pos = int'(start_i) + k;
      if (pos >= WIDTH) pos = pos - WIDTH;
      if (!found_o && vec_i[IDX_W'(pos)]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(pos);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/edge_event_reader.sv
// +---------------------------------------------------------------------------+
// | edge_event_reader : latches per-bit edge pulses and streams pending source |
// | indices on valid/ready. Define EDGE_READER_RR_EN for round-robin pick.     |
// | Revision          : 1.0                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module edge_event_reader
  import edge_pkg::*;
#(
  parameter int WIDTH = EDGE_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] edge_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDX_W-1:0] evt_idx_o,
  output logic [WIDTH-1:0] pending_o,
  output logic [WIDTH-1:0] drop_o,
  input  logic             drop_clr_i
);

  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] drop_q, drop_d;
  logic [WIDTH-1:0] load_vec;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             out_free;
  logic             do_load;

  assign out_free = ~valid_q | evt_ready_i;
  assign do_load  = out_free & sel_found;

  edge_find_first #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_find (
    .vec_i   (pending_q),
    .start_i (start_idx),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

`ifdef EDGE_READER_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign start_idx = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (do_load) ptr_d = IDX_W'(wrap_inc(int'(sel_idx), WIDTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign start_idx = '0;
`endif

  always_comb begin
    load_vec = '0;
    if (do_load) load_vec[sel_idx] = 1'b1;
  end

  // A pulse landing on the bit being loaded re-queues it instead of dropping.
  always_comb begin
    pending_d = (pending_q & ~load_vec) | edge_i;
    drop_d    = (drop_clr_i ? '0 : drop_q) | (edge_i & pending_q & ~load_vec);
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    if (out_free) begin
      valid_d = sel_found;
      if (sel_found) idx_d = sel_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      drop_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_idx_o   = idx_q;
  assign pending_o   = pending_q;
  assign drop_o      = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_event_reader.sv
// +---------------------------------------------------------------------------+
// | tb_edge_event_reader : directed and randomized checks of edge_event_reader |
// | against an event-level reference model. Revision 1.0                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_edge_event_reader;

  logic        clk;
  logic        reset;
  logic [31:0] edge_i;
  logic        evt_ready_i;
  logic        drop_clr_i;
  logic        evt_valid_o;
  logic [4:0]  evt_idx_o;
  logic [31:0] pending_o;
  logic [31:0] drop_o;

  int checks;
  int passes;

  // Reference model state
  bit        m_valid;
  int        m_idx;
  bit [31:0] m_pend;
  bit [31:0] m_drop;
  int        m_ptr;

  edge_event_reader dut (
    .clk         (clk),
    .reset       (reset),
    .edge_i      (edge_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_idx_o   (evt_idx_o),
    .pending_o   (pending_o),
    .drop_o      (drop_o),
    .drop_clr_i  (drop_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_zero();
    m_valid = 0; m_idx = 0; m_pend = '0; m_drop = '0; m_ptr = 0;
  endtask

  task automatic model_clock();
    bit        free;
    int        sel;
    int        b;
    bit [31:0] np;
    bit [31:0] nd;
    if (!reset) begin
      model_zero();
      return;
    end
    free = !m_valid || evt_ready_i;
    sel  = -1;
    if (free) begin
      for (int k = 0; k < 32; k++) begin
`ifdef EDGE_READER_RR_EN
        b = (m_ptr + k) % 32;
`else
        b = k;
`endif
        if (sel < 0 && m_pend[b]) sel = b;
      end
    end
    np = m_pend;
    nd = drop_clr_i ? 32'h0 : m_drop;
    for (int i = 0; i < 32; i++) begin
      if (edge_i[i]) begin
        if (m_pend[i] && i != sel) nd[i] = 1'b1;
        np[i] = 1'b1;
      end else if (i == sel) begin
        np[i] = 1'b0;
      end
    end
    if (free) begin
      m_valid = (sel >= 0);
      if (sel >= 0) begin
        m_idx = sel;
        m_ptr = (sel + 1) % 32;
      end
    end
    m_pend = np;
    m_drop = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; edge_i = 32'hFFFF_FFFF; evt_ready_i = 1'b0; drop_clr_i = 1'b0;
    model_zero();
    repeat (3) tick();
    checks++; if (evt_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", evt_valid_o); else passes++;
    checks++; if (evt_idx_o !== 5'd0) $display("FAIL reset_idx: got %0d expected 0", evt_idx_o); else passes++;
    checks++; if (pending_o !== 32'h0) $display("FAIL reset_pending: got %h expected 0", pending_o); else passes++;
    checks++; if (drop_o !== 32'h0) $display("FAIL reset_drop: got %h expected 0", drop_o); else passes++;
    edge_i = 32'h0; reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (evt_valid_o !== 1'b0 || pending_o !== 32'h0)
        $display("FAIL reset_release_idle: got valid=%b pending=%h expected valid=0 pending=0", evt_valid_o, pending_o);
      else passes++;
    end
  endtask

  task automatic test_single();
    evt_ready_i = 1'b1; edge_i = 32'h10;
    tick();
    edge_i = 32'h0;
    checks++; if (evt_valid_o !== 1'b0 || pending_o !== 32'h10)
      $display("FAIL single_edge_k: got valid=%b pending=%h expected valid=0 pending=00000010", evt_valid_o, pending_o);
    else passes++;
    tick();
    checks++; if (evt_valid_o !== 1'b1 || evt_idx_o !== 5'd4 || pending_o !== 32'h0)
      $display("FAIL single_edge_k1: got valid=%b idx=%0d pending=%h expected valid=1 idx=4 pending=0", evt_valid_o, evt_idx_o, pending_o);
    else passes++;
    tick();
    checks++; if (evt_valid_o !== 1'b0)
      $display("FAIL single_one_cycle: got valid=%b expected 0", evt_valid_o);
    else passes++;
  endtask

  task automatic test_backpressure();
    evt_ready_i = 1'b0; edge_i = 32'h88;
    tick();
    edge_i = 32'h0;
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (evt_valid_o !== 1'b1 || evt_idx_o !== 5'd3 || pending_o !== 32'h80)
        $display("FAIL bp_hold: got valid=%b idx=%0d pending=%h expected valid=1 idx=3 pending=00000080", evt_valid_o, evt_idx_o, pending_o);
      else passes++;
      tick();
    end
    evt_ready_i = 1'b1;
    tick();
    checks++; if (evt_valid_o !== 1'b1 || evt_idx_o !== 5'd7 || pending_o !== 32'h0)
      $display("FAIL bp_next: got valid=%b idx=%0d pending=%h expected valid=1 idx=7 pending=0", evt_valid_o, evt_idx_o, pending_o);
    else passes++;
    tick();
    checks++; if (evt_valid_o !== 1'b0)
      $display("FAIL bp_drain: got valid=%b expected 0", evt_valid_o);
    else passes++;
  endtask

  task automatic test_drop();
    int fives;
    evt_ready_i = 1'b0;
    edge_i = 32'h1;  tick();
    edge_i = 32'h20; tick();
    edge_i = 32'h0;  tick();
    edge_i = 32'h20; tick();
    edge_i = 32'h0;  tick();
    checks++; if (drop_o !== 32'h20 || evt_idx_o !== 5'd0 || pending_o !== 32'h20)
      $display("FAIL drop_set: got drop=%h idx=%0d pending=%h expected drop=00000020 idx=0 pending=00000020", drop_o, evt_idx_o, pending_o);
    else passes++;
    evt_ready_i = 1'b1;
    fives = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (evt_valid_o && evt_idx_o == 5'd5) fives++;
    end
    checks++; if (fives != 1) $display("FAIL drop_single_delivery: got %0d index-5 events expected 1", fives); else passes++;
    evt_ready_i = 1'b0; drop_clr_i = 1'b1;
    tick();
    drop_clr_i = 1'b0;
    checks++; if (drop_o !== 32'h0) $display("FAIL drop_clear: got %h expected 0", drop_o); else passes++;
    edge_i = 32'h1;   tick();
    edge_i = 32'h200; tick();
    edge_i = 32'h200; drop_clr_i = 1'b1; tick();
    edge_i = 32'h0;   drop_clr_i = 1'b0;
    checks++; if (drop_o !== 32'h200) $display("FAIL drop_set_wins: got %h expected 00000200", drop_o); else passes++;
    evt_ready_i = 1'b1;
    repeat (4) tick();
    drop_clr_i = 1'b1; tick(); drop_clr_i = 1'b0;
  endtask

  task automatic test_arbitration();
    int prev;
    prev = -1;
    evt_ready_i = 1'b1; edge_i = 32'h6;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (evt_valid_o) begin
        checks++;
`ifdef EDGE_READER_RR_EN
        if ((evt_idx_o != 5'd1 && evt_idx_o != 5'd2) || int'(evt_idx_o) == prev || int'(evt_idx_o) != m_idx)
          $display("FAIL arb_rr: got idx=%0d prev=%0d expected alternating 1/2 (model %0d)", evt_idx_o, prev, m_idx);
        else passes++;
`else
        if (evt_idx_o !== 5'd1)
          $display("FAIL arb_fixed: got idx=%0d expected 1", evt_idx_o);
        else passes++;
`endif
        prev = int'(evt_idx_o);
      end
    end
`ifndef EDGE_READER_RR_EN
    checks++; if (drop_o[2] !== 1'b1) $display("FAIL arb_fixed_drop2: got %b expected 1", drop_o[2]); else passes++;
`endif
    edge_i = 32'h0;
    repeat (4) tick();
    drop_clr_i = 1'b1; tick(); drop_clr_i = 1'b0;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      edge_i      = $urandom & $urandom & $urandom;
      evt_ready_i = ($urandom_range(0, 3) != 0);
      drop_clr_i  = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (evt_valid_o !== m_valid || pending_o !== m_pend || drop_o !== m_drop ||
          (m_valid && int'(evt_idx_o) != m_idx)) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_cycle_%0d: got valid=%b idx=%0d pending=%h drop=%h expected valid=%b idx=%0d pending=%h drop=%h",
                   i, evt_valid_o, evt_idx_o, pending_o, drop_o, m_valid, m_idx, m_pend, m_drop);
      end else passes++;
    end
    edge_i = 32'h0; drop_clr_i = 1'b0; evt_ready_i = 1'b1;
    repeat (40) tick();
  endtask

  task automatic test_reset_mid();
    evt_ready_i = 1'b0; edge_i = 32'h154;
    tick();
    edge_i = 32'h0;
    tick();
    checks++; if (evt_valid_o !== 1'b1 || evt_idx_o !== 5'd2 || pending_o !== 32'h150)
      $display("FAIL midrst_pre: got valid=%b idx=%0d pending=%h expected valid=1 idx=2 pending=00000150", evt_valid_o, evt_idx_o, pending_o);
    else passes++;
    reset = 1'b0;
    #1;
    model_zero();
    checks++; if (evt_valid_o !== 1'b0 || evt_idx_o !== 5'd0 || pending_o !== 32'h0 || drop_o !== 32'h0)
      $display("FAIL midrst_async: got valid=%b idx=%0d pending=%h drop=%h expected all 0", evt_valid_o, evt_idx_o, pending_o, drop_o);
    else passes++;
    repeat (2) tick();
    reset = 1'b1; evt_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (evt_valid_o !== 1'b0 || pending_o !== 32'h0)
        $display("FAIL midrst_no_replay: got valid=%b pending=%h expected valid=0 pending=0", evt_valid_o, pending_o);
      else passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_drop();
    test_arbitration();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
